// File: rtl/clock_gen_if.sv
// Run-control and derived-clock signals between clock_gen and its consumers.
// The generator drives the clock-side outputs; the consumer owns the run enable.
interface clock_gen_if #(
  parameter int unsigned CNT_W = 32
) ();

  logic             en;
  logic             clk_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] cycle_count;
  logic             done;

  modport master (
    input  en,
    output clk_out,
    output rise_pulse,
    output fall_pulse,
    output cycle_count,
    output done
  );

  modport slave (
    output en,
    input  clk_out,
    input  rise_pulse,
    input  fall_pulse,
    input  cycle_count,
    input  done
  );

endinterface

// File: rtl/clock_gen.sv
// Divides the reference clock into a registered 50%-duty clock with edge strobes,
// a rising-edge counter and an optional run limit that parks the clock high.
module clock_gen #(
  parameter int unsigned PERIOD     = 10,
  parameter int unsigned MAX_CYCLES = 0,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  clock_gen_if.master bus
);

  localparam int unsigned High = PERIOD / 2;
  localparam int unsigned Low  = PERIOD - High;
  localparam int unsigned PhW  = 16;

  localparam logic [PhW-1:0] LowLim  = PhW'(Low - 1);
  localparam logic [PhW-1:0] HighLim = PhW'(High - 1);

  if (PERIOD < 2 || PERIOD > 65535) begin : gen_bad_period
    $error("clock_gen: PERIOD must be in 2..65535");
  end

  logic [PhW-1:0]   phase_q, phase_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [PhW-1:0]   lim;

  always_comb begin
    phase_d   = phase_q;
    clk_out_d = clk_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    cnt_d     = cnt_q;
    done_d    = done_q;
    lim       = clk_out_q ? HighLim : LowLim;

    if (bus.en && !done_q) begin
      if (phase_q == lim) begin
        phase_d   = '0;
        clk_out_d = ~clk_out_q;
        rise_d    = ~clk_out_q;
        fall_d    = clk_out_q;
        if (!clk_out_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Limit reached on this rise: clock stays high from here on.
          if (MAX_CYCLES != 0 && cnt_d == CNT_W'(MAX_CYCLES)) begin
            done_d = 1'b1;
          end
        end
      end else begin
        phase_d = phase_q + PhW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= '0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign bus.clk_out     = clk_out_q;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.cycle_count = cnt_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed checks of clock_gen across four configurations sharing one reference clock.
module tb_clock_gen;

  logic clk;
  logic reset;

  int unsigned n_total;
  int unsigned n_bad;

  clock_gen_if #(.CNT_W(32)) if0 ();
  clock_gen_if #(.CNT_W(32)) if1 ();
  clock_gen_if #(.CNT_W(32)) if2 ();
  clock_gen_if #(.CNT_W(4))  if3 ();

  clock_gen #(.PERIOD(10), .MAX_CYCLES(0), .CNT_W(32)) u_p10 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  clock_gen #(.PERIOD(3), .MAX_CYCLES(0), .CNT_W(32)) u_p3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  clock_gen #(.PERIOD(4), .MAX_CYCLES(3), .CNT_W(32)) u_p4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  clock_gen #(.PERIOD(2), .MAX_CYCLES(0), .CNT_W(4)) u_p2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int unsigned overlap;
  int unsigned rises0;
  int unsigned frozen_bad;

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    if0.en  = 1'b1;
    if1.en  = 1'b1;
    if2.en  = 1'b1;
    if3.en  = 1'b1;

    // Reset state (en held high: reset must win)
    tick();
    tick();
    check_eq("rst_clk_out", 32'(if0.clk_out), 32'd0);
    check_eq("rst_rise",    32'(if0.rise_pulse), 32'd0);
    check_eq("rst_fall",    32'(if0.fall_pulse), 32'd0);
    check_eq("rst_count",   if0.cycle_count, 32'd0);
    check_eq("rst_done",    32'(if2.done), 32'd0);
    reset = 1'b0;

    // Free run on all four instances
    overlap = 0;
    rises0  = 0;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (if0.rise_pulse && if0.fall_pulse) overlap++;
      if (if1.rise_pulse && if1.fall_pulse) overlap++;
      if (c <= 15 && if0.rise_pulse) rises0++;
      case (c)
        2: begin
          check_eq("p3_rise_c2", 32'(if1.rise_pulse), 32'd1);
          check_eq("p3_clk_c2",  32'(if1.clk_out), 32'd1);
        end
        3: begin
          check_eq("p3_fall_c3", 32'(if1.fall_pulse), 32'd1);
          check_eq("p3_clk_c3",  32'(if1.clk_out), 32'd0);
        end
        4: check_eq("p10_clk_c4", 32'(if0.clk_out), 32'd0);
        5: begin
          check_eq("p10_clk_c5",   32'(if0.clk_out), 32'd1);
          check_eq("p10_rise_c5",  32'(if0.rise_pulse), 32'd1);
          check_eq("p10_count_c5", if0.cycle_count, 32'd1);
          check_eq("p3_rise_c5",   32'(if1.rise_pulse), 32'd1);
        end
        6: check_eq("p3_fall_c6", 32'(if1.fall_pulse), 32'd1);
        8: check_eq("p3_count_c8", if1.cycle_count, 32'd3);
        9: begin
          check_eq("p10_clk_c9", 32'(if0.clk_out), 32'd1);
          check_eq("p4_done_c9", 32'(if2.done), 32'd0);
        end
        10: begin
          check_eq("p10_clk_c10",  32'(if0.clk_out), 32'd0);
          check_eq("p10_fall_c10", 32'(if0.fall_pulse), 32'd1);
          check_eq("p4_done_c10",  32'(if2.done), 32'd1);
          check_eq("p4_rise_c10",  32'(if2.rise_pulse), 32'd1);
          check_eq("p4_count_c10", if2.cycle_count, 32'd3);
        end
        14: check_eq("p10_rise_c14", 32'(if0.rise_pulse), 32'd0);
        15: begin
          check_eq("p10_clk_c15",   32'(if0.clk_out), 32'd1);
          check_eq("p10_count_c15", if0.cycle_count, 32'd2);
        end
        29: check_eq("p2_count_c29", 32'(if3.cycle_count), 32'd15);
        30: begin
          check_eq("p4_clk_c30",   32'(if2.clk_out), 32'd1);
          check_eq("p4_count_c30", if2.cycle_count, 32'd3);
          check_eq("p4_rise_c30",  32'(if2.rise_pulse), 32'd0);
          check_eq("p4_done_c30",  32'(if2.done), 32'd1);
        end
        31: check_eq("p2_count_c31", 32'(if3.cycle_count), 32'd0);
        33: begin
          check_eq("p2_count_c33", 32'(if3.cycle_count), 32'd1);
          check_eq("p2_done_c33",  32'(if3.done), 32'd0);
        end
        default: ;
      endcase
    end
    check_eq("pulse_overlap", overlap, 32'd0);
    check_eq("p10_rises_15",  rises0, 32'd2);

    // Enable dropped for 7 cycles at phase 2 of the low half
    do_reset();
    frozen_bad = 0;
    for (int c = 1; c <= 12; c++) begin
      if0.en = !(c >= 3 && c <= 9);
      tick();
      if (c >= 3 && c <= 9 && (if0.clk_out || if0.rise_pulse || if0.fall_pulse)) frozen_bad++;
      if (c == 5)  check_eq("en_clk_c5",   32'(if0.clk_out), 32'd0);
      if (c == 11) check_eq("en_clk_c11",  32'(if0.clk_out), 32'd0);
      if (c == 12) begin
        check_eq("en_clk_c12",   32'(if0.clk_out), 32'd1);
        check_eq("en_rise_c12",  32'(if0.rise_pulse), 32'd1);
        check_eq("en_count_c12", if0.cycle_count, 32'd1);
      end
    end
    check_eq("en_frozen", frozen_bad, 32'd0);
    if0.en = 1'b1;

    // Reset mid high phase at cycle_count=7
    do_reset();
    for (int c = 1; c <= 66; c++) tick();
    check_eq("mid_count_pre", if0.cycle_count, 32'd7);
    check_eq("mid_clk_pre",   32'(if0.clk_out), 32'd1);
    check_eq("mid_done_pre",  32'(if2.done), 32'd1);
    do_reset();
    check_eq("mid_clk_rst",   32'(if0.clk_out), 32'd0);
    check_eq("mid_count_rst", if0.cycle_count, 32'd0);
    check_eq("mid_rise_rst",  32'(if0.rise_pulse), 32'd0);
    check_eq("mid_fall_rst",  32'(if0.fall_pulse), 32'd0);
    check_eq("mid_done_rst",  32'(if2.done), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) check_eq("mid_clk_c4", 32'(if0.clk_out), 32'd0);
      if (c == 5) begin
        check_eq("mid_clk_c5",   32'(if0.clk_out), 32'd1);
        check_eq("mid_count_c5", if0.cycle_count, 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
- Synthesizable clock generator and divider, registered in the reference clock domain.
- Produces a derived 50%-duty clock `clk_out` of PERIOD reference cycles, plus single-cycle rise/fall strobes and a derived-cycle counter.
- Supports run-limit stop (`done`) so the pipeline testbenches can be driven and terminated from one block.
- Sits at the top of the processor environment and feeds the pipeline and print/monitor logic.

Parameters:
- PERIOD, 10, derived clock period in reference `clk` cycles; legal range 2..65535. Elaboration fails if PERIOD < 2.
- MAX_CYCLES, 0, number of derived rising edges after which generation stops; 0 means unlimited.
- CNT_W, 32, width of `cycle_count`.

Ports:
- clk  input  1  reference clock; all logic on its posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  run enable; 0 freezes all state.
- clk_out  output  1  derived clock, registered.
- rise_pulse  output  1  high for exactly one `clk` cycle, coincident with the cycle in which `clk_out` becomes 1.
- fall_pulse  output  1  high for exactly one `clk` cycle, coincident with the cycle in which `clk_out` becomes 0.
- cycle_count  output  CNT_W  number of `clk_out` rising edges since reset.
- done  output  1  sticky; high once MAX_CYCLES rising edges have been produced.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (sampled at posedge `clk`) forces:
  - `clk_out`=0, `rise_pulse`=0, `fall_pulse`=0;
  - `cycle_count`=0, `done`=0;
  - internal phase counter=0.
- Reset overrides `en`. Reset mid-period discards the partial phase; the first edge after reset always follows the full low phase.
- Phase lengths:
  - LOW = PERIOD − PERIOD/2 (integer division).
  - HIGH = PERIOD/2.
  - Odd PERIOD therefore has a low phase one cycle longer than the high phase.
- Active cycle (en=1, done=0, reset=0):
  - Let `lim` = LOW−1 while `clk_out`=0, or HIGH−1 while `clk_out`=1.
  - If phase==`lim`: phase←0, `clk_out`←~`clk_out`, `rise_pulse`←~`clk_out`(old), `fall_pulse`←`clk_out`(old).
  - Otherwise: phase←phase+1, `rise_pulse`←0, `fall_pulse`←0.
- `cycle_count` increments in the same cycle `rise_pulse` is registered high. It wraps modulo 2^CNT_W with no flag.
- `done`:
  - If MAX_CYCLES≠0 and the incremented `cycle_count` equals MAX_CYCLES, `done`←1 in that same cycle.
  - Thereafter `clk_out` holds its current value (1), both pulses are 0, and phase and count are frozen until reset.
- en=0:
  - All state holds, including phase and `clk_out`; `rise_pulse` and `fall_pulse` are 0.
  - Re-enabling resumes from the held phase with no lost or extra edges.
- First rising edge after reset release: `clk_out`=1 registered at the LOW-th enabled posedge (PERIOD=10 → 5th cycle).
- Steady state: rising edges exactly PERIOD enabled cycles apart; `rise_pulse` and `fall_pulse` never both high.
- Latency: outputs are purely registered; no combinational path from inputs to outputs.

Test Plan:
- PERIOD=10, MAX_CYCLES=0: reset 1 cycle, en=1 → `clk_out` rises on enabled cycle 5, falls on 10, rises on 15; `cycle_count`=1 at cycle 5, 2 at cycle 15; exactly one `rise_pulse` per rise.
- PERIOD=3 (odd): → low 2 cycles, high 1 cycle; rise at cycles 2, 5, 8; `fall_pulse` at 3, 6.
- PERIOD=10, en dropped for 7 cycles at phase 2 of the low half → `clk_out` frozen, no pulses, next rise delayed exactly 7 cycles (cycle 12 instead of 5).
- PERIOD=4, MAX_CYCLES=3: → `done`=1 together with the 3rd `rise_pulse` (cycle 10); `clk_out` stays 1; `cycle_count` stays 3 for 20 more cycles.
- Reset asserted mid high phase at `cycle_count`=7 → next cycle all outputs 0; first rise after release occurs LOW cycles later; `done` cleared.
- CNT_W=4, PERIOD=2: run 17 rises → `cycle_count` wraps 15→0→1, no `done` when MAX_CYCLES=0.
